pcie_ts_wr_v2: RTL
==================

// Module: pcie_ts_wr_v2
// PURPOSE
//  PCIe-to-TS write path, the counterpart of the TS-to-PCIe DMA read path.
//  Host DMA pushes 64-bit beats addressed by dma_waddr; the block packs 8 beats into one 512-bit word.
//  Words go into a 2-bank ping-pong TS buffer RAM (dvb_*). Each filled bank is handed to the TS sender with blk_rdy.
//  Sits between the PCIe DMA engine and the TS output scheduler, all in the clk_pcie domain.
// PARAMETERS
//  BANK_WORDS  32  512-bit words per bank (power of 2); dvb_waddr = {bank, word[4:0]}
//  BEATS       8   64-bit beats per 512-bit word (fixed)
// PORTS
//  clk_pcie         in   1    PCIe user clock; the only clock
//  rst_pcie         in   1    asynchronous, active-low reset
//  dma_read_start   in   1    1-cycle pulse: host begins a TS block transfer
//  dma_read_end     in   1    1-cycle pulse: host transfer finished
//  dma_wdata_en     in   1    beat valid
//  dma_waddr        in   32   byte address of beat within transfer
//  dma_wdata        in   64   beat data
//  dma_wdata_busy   out  1    1 = beats are not accepted this cycle
//  dvb_wr           out  1    buffer RAM write enable
//  dvb_waddr        out  6    buffer RAM word address {bank, word}
//  dvb_dina         out  512  buffer RAM write data
//  ts_bank_free     in   2    1-cycle pulse per bank: TS sender has drained it
//  blk_rdy          out  1    1-cycle pulse: bank committed
//  blk_bank         out  1    committed bank index, valid with blk_rdy
//  blk_words        out  6    committed word count 1..32, valid with blk_rdy
//  wr_err           out  1    sticky: dropped or misaddressed beat; cleared only by reset or dma_read_start
// BEHAVIOUR
//  Reset: all outputs 0 except dma_wdata_busy=1. State=IDLE, cur_bank=0, bank_full=2'b00, counters 0.
//  FSM states: IDLE, WAIT_BANK, FILL, FLUSH, COMMIT.
//   IDLE: on dma_read_start, if bank_full[cur_bank] go to WAIT_BANK, else go to FILL.
//   WAIT_BANK: stay until bank_full[cur_bank]==0, then go to FILL.
//   FILL: dma_wdata_busy=0 only in this state.
//    Accepted beat i = dma_waddr[5:3] goes to dvb_dina[64*i+63:64*i] (beat 0 = LSBs).
//    Expected beat = beat_cnt. If dma_waddr[2:0]!=0, or the beat index mismatches, or the word index dma_waddr[10:6] mismatches word_cnt:
//     set wr_err and drop the beat (counters unchanged).
//    8th beat accepted -> next cycle: dvb_wr=1, dvb_waddr={cur_bank,word_cnt}, word_cnt+1.
//    After word 31 is written -> COMMIT.
//    dma_read_end -> FLUSH. A final beat arriving in the same cycle is accepted first.
//   FLUSH: if beat_cnt>0, write the partial word with missing lanes zero, 1 cycle.
//    Then go to COMMIT if word_cnt>0, else IDLE.
//   COMMIT: blk_rdy=1 for 1 cycle, blk_bank=cur_bank, blk_words=word_cnt (32 encodes as 6'd32).
//    Set bank_full[cur_bank], toggle cur_bank, clear counters.
//    Then: if the transfer is still open (no dma_read_end yet), go to WAIT_BANK or FILL per bank_full;
//    else go to IDLE.
//  Latency: 8th beat -> dvb_wr 1 cycle. Last dvb_wr -> blk_rdy 1 cycle.
//  Beats with dma_wdata_en while busy: dropped, wr_err=1.
//  ts_bank_free[b] clears bank_full[b]. If set and clear hit the same bank in the same cycle, set wins.
//  dma_read_start while not IDLE: ignored and wr_err=1.
//  dma_read_end in IDLE or WAIT_BANK: transfer closes, state returns to IDLE, nothing is committed.
//  Async reset mid-transfer: partial words and banks are discarded; no blk_rdy.
// TESTING
//  T1 start, 256 in-order beats at addr 0..0x7F8 -> 32 dvb_wr at addr 0..31, then blk_rdy bank0 words=32, no wr_err.
//  T2 start, 20 beats then end -> 2 full words, then flush word2 with lanes 4..7 = 0, then blk_rdy words=3.
//  T3 512 beats with no ts_bank_free -> bank0 and bank1 commit, busy=1 held. Free bank0 -> FILL resumes at dvb_waddr=0.
//  T4 beat with addr 0x48 when 0x40 is expected -> beat dropped, wr_err=1; resend 0x40 -> accepted.
//  T5 reset asserted after 100 beats -> all outputs at reset values, later start fills bank0 from word 0.
//  T6 ts_bank_free[0] in the same cycle as bank0 commit -> bank_full[0]=1 afterwards.

Source files
------------

// File: rtl/pcie_ts_wr_v2.sv
// pcie_ts_wr_v2 : PCIe-to-TS write path.
//
// Host DMA beats (64-bit) are packed eight at a time into 512-bit words.
// Each word is written into a two-bank ping-pong TS buffer RAM. When a bank
// is complete, or the host closes the transfer, the bank is handed to the TS
// sender with a one-cycle blk_rdy pulse.
//
// Ports
//   clk_pcie, rst_pcie      : clock, asynchronous active-low reset
//   dma_read_start/end      : one-cycle pulses that open/close a host transfer
//   dma_wdata_en/waddr/wdata: beat valid, byte address within transfer, data
//   dma_wdata_busy          : 1 = beats are not accepted this cycle
//   dvb_wr/waddr/dina       : buffer RAM write port, address = {bank, word}
//   ts_bank_free            : per-bank pulse from the TS sender, bank drained
//   blk_rdy/bank/words      : bank commit pulse with bank index and word count
//   wr_err                  : sticky error, dropped or misaddressed beat
module pcie_ts_wr_v2 #(
    parameter int  BANK_WORDS = 32,
    parameter int  BEATS      = 8,
    parameter int  DATA_W     = 64,
    localparam int WORD_W     = $clog2(BANK_WORDS),
    localparam int BEAT_W     = $clog2(BEATS),
    localparam int OFS_W      = $clog2(DATA_W / 8)
) (
    input  logic                      clk_pcie,
    input  logic                      rst_pcie,
    input  logic                      dma_read_start,
    input  logic                      dma_read_end,
    input  logic                      dma_wdata_en,
    input  logic [31:0]               dma_waddr,
    input  logic [DATA_W-1:0]         dma_wdata,
    output logic                      dma_wdata_busy,
    output logic                      dvb_wr,
    output logic [WORD_W:0]           dvb_waddr,
    output logic [DATA_W*BEATS-1:0]   dvb_dina,
    input  logic [1:0]                ts_bank_free,
    output logic                      blk_rdy,
    output logic                      blk_bank,
    output logic [WORD_W:0]           blk_words,
    output logic                      wr_err
);

    typedef enum logic [2:0] {IDLE, WAIT_BANK, FILL, FLUSH, COMMIT} state_t;

    state_t                    state;
    logic                      cur_bank;
    logic [1:0]                bank_full;
    logic [BEAT_W-1:0]         beat_cnt;
    logic [WORD_W:0]           word_cnt;     // one extra bit so a full bank reads as BANK_WORDS
    logic                      xfer_open;
    logic [DATA_W*BEATS-1:0]   word_buf;
    logic [DATA_W*BEATS-1:0]   buf_next;

    logic [BEAT_W-1:0]         addr_beat;
    logic [WORD_W-1:0]         addr_word;
    logic                      addr_ok;
    logic                      in_fill;
    logic                      beat_take;
    logic                      beat_bad;
    logic                      start_bad;
    logic                      word_done;
    logic                      last_word;
    logic [1:0]                commit_set;

    // Beat address decode: {.., word, beat, byte offset}
    assign addr_beat  = dma_waddr[OFS_W +: BEAT_W];
    assign addr_word  = dma_waddr[OFS_W+BEAT_W +: WORD_W];
    assign addr_ok    = (dma_waddr[OFS_W-1:0] == '0) &&
                        (addr_beat == beat_cnt) &&
                        (addr_word == word_cnt[WORD_W-1:0]);

    assign in_fill    = (state == FILL);
    assign beat_take  = in_fill && dma_wdata_en && addr_ok;
    assign beat_bad   = dma_wdata_en && !(in_fill && addr_ok);
    assign start_bad  = dma_read_start && (state != IDLE);
    assign word_done  = beat_take && (beat_cnt == BEAT_W'(BEATS - 1));
    assign last_word  = (word_cnt == (WORD_W+1)'(BANK_WORDS - 1));
    assign commit_set = (state == COMMIT) ? (2'b01 << cur_bank) : 2'b00;

    assign dma_wdata_busy = !in_fill;

    // Lane merge of the incoming beat; beat 0 lands in the LSBs
    always_comb begin
        buf_next = word_buf;
        buf_next[DATA_W*beat_cnt +: DATA_W] = dma_wdata;
    end

    always_ff @(posedge clk_pcie or negedge rst_pcie) begin
        if (!rst_pcie) begin
            state     <= IDLE;
            cur_bank  <= 1'b0;
            bank_full <= 2'b00;
            beat_cnt  <= '0;
            word_cnt  <= '0;
            xfer_open <= 1'b0;
            word_buf  <= '0;
            dvb_wr    <= 1'b0;
            dvb_waddr <= '0;
            dvb_dina  <= '0;
            blk_rdy   <= 1'b0;
            blk_bank  <= 1'b0;
            blk_words <= '0;
            wr_err    <= 1'b0;
        end else begin
            dvb_wr  <= 1'b0;
            blk_rdy <= 1'b0;

            // A commit setting a bank beats a simultaneous free of that bank
            bank_full <= (bank_full & ~ts_bank_free) | commit_set;

            if (dma_read_end)
                xfer_open <= 1'b0;

            if (dma_read_start && state == IDLE)
                wr_err <= 1'b0;
            if (beat_bad || start_bad)
                wr_err <= 1'b1;

            // Pack stage: accepted beat into the word buffer, full word to RAM
            if (beat_take) begin
                word_buf <= buf_next;
                beat_cnt <= beat_cnt + 1'b1;
                if (word_done) begin
                    dvb_wr    <= 1'b1;
                    dvb_waddr <= {cur_bank, word_cnt[WORD_W-1:0]};
                    dvb_dina  <= buf_next;
                    word_buf  <= '0;
                    beat_cnt  <= '0;
                    word_cnt  <= word_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (dma_read_start && !dma_read_end) begin
                        xfer_open <= 1'b1;
                        state     <= bank_full[cur_bank] ? WAIT_BANK : FILL;
                    end
                end
                WAIT_BANK: begin
                    if (dma_read_end)
                        state <= IDLE;
                    else if (!bank_full[cur_bank])
                        state <= FILL;
                end
                FILL: begin
                    // A word completing together with end already has data to commit
                    if (word_done && (last_word || dma_read_end))
                        state <= COMMIT;
                    else if (dma_read_end)
                        state <= FLUSH;
                end
                FLUSH: begin
                    // Unwritten lanes are still zero from the last word clear
                    if (beat_cnt != '0) begin
                        dvb_wr    <= 1'b1;
                        dvb_waddr <= {cur_bank, word_cnt[WORD_W-1:0]};
                        dvb_dina  <= word_buf;
                        word_buf  <= '0;
                        beat_cnt  <= '0;
                        word_cnt  <= word_cnt + 1'b1;
                        state     <= COMMIT;
                    end else begin
                        state <= (word_cnt != '0) ? COMMIT : IDLE;
                    end
                end
                COMMIT: begin
                    blk_rdy   <= 1'b1;
                    blk_bank  <= cur_bank;
                    blk_words <= word_cnt;
                    cur_bank  <= ~cur_bank;
                    word_cnt  <= '0;
                    beat_cnt  <= '0;
                    word_buf  <= '0;
                    if (xfer_open && !dma_read_end)
                        state <= bank_full[~cur_bank] ? WAIT_BANK : FILL;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
